// File: rtl/apb_rr_master_arb_if.sv
// Bundle of the two-requester front end and the APB4 master bus driven by apb_rr_master_arb.
// The master modport is the arbiter's view; the slave modport is the requesters plus the APB slave.
interface apb_rr_master_arb_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int PROT_WIDTH = 3
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  // requester side
  logic [1:0]              req;
  logic [1:0]              req_write;
  logic [2*ADDR_WIDTH-1:0] req_addr;
  logic [2*DATA_WIDTH-1:0] req_wdata;
  logic [2*STRB_WIDTH-1:0] req_strb;
  logic [2*PROT_WIDTH-1:0] req_prot;
  logic [1:0]              req_done;
  logic [DATA_WIDTH-1:0]   req_rdata;
  logic                    req_err;
  logic                    busy;

  // APB4 side
  logic                    PSEL;
  logic                    PENABLE;
  logic                    PWRITE;
  logic [ADDR_WIDTH-1:0]   PADDR;
  logic [DATA_WIDTH-1:0]   PWDATA;
  logic [STRB_WIDTH-1:0]   PSTRB;
  logic [PROT_WIDTH-1:0]   PPROT;
  logic                    PREADY;
  logic                    PSLVERR;
  logic [DATA_WIDTH-1:0]   PRDATA;

  modport master (
    input  req, req_write, req_addr, req_wdata, req_strb, req_prot,
    input  PREADY, PSLVERR, PRDATA,
    output req_done, req_rdata, req_err, busy,
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT
  );

  modport slave (
    output req, req_write, req_addr, req_wdata, req_strb, req_prot,
    output PREADY, PSLVERR, PRDATA,
    input  req_done, req_rdata, req_err, busy,
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT
  );
endinterface

// File: rtl/apb_rr_master_arb.sv
// Two-requester round-robin arbiter driving a single APB4 master port.
// Every output is a register; a watchdog aborts ACCESS phases that never see PREADY.
module apb_rr_master_arb #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int PROT_WIDTH = 3,
  parameter int TIMEOUT    = 16
) (
  input  logic                PCLK,
  input  logic                PRESETn,
  apb_rr_master_arb_if.master bus
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int CNT_WIDTH  = $clog2(TIMEOUT + 2);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t                 state_reg, state_next;
  logic                   last_grant_reg, last_grant_next;
  logic                   grant_reg, grant_next;
  logic [CNT_WIDTH-1:0]   wait_cnt_reg, wait_cnt_next;

  logic                   psel_reg, psel_next;
  logic                   penable_reg, penable_next;
  logic                   pwrite_reg, pwrite_next;
  logic [ADDR_WIDTH-1:0]  paddr_reg, paddr_next;
  logic [DATA_WIDTH-1:0]  pwdata_reg, pwdata_next;
  logic [STRB_WIDTH-1:0]  pstrb_reg, pstrb_next;
  logic [PROT_WIDTH-1:0]  pprot_reg, pprot_next;
  logic [1:0]             done_reg, done_next;
  logic [DATA_WIDTH-1:0]  rdata_reg, rdata_next;
  logic                   err_reg, err_next;
  logic                   busy_reg, busy_next;

  // Per-requester views of the packed request buses.
  logic                   write_arr [2];
  logic [ADDR_WIDTH-1:0]  addr_arr  [2];
  logic [DATA_WIDTH-1:0]  wdata_arr [2];
  logic [STRB_WIDTH-1:0]  strb_arr  [2];
  logic [PROT_WIDTH-1:0]  prot_arr  [2];
  logic [1:0]             eligible;
  logic                   winner;
  logic                   timeout_hit;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_req
      assign write_arr[gi] = bus.req_write[gi];
      assign addr_arr[gi]  = bus.req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign wdata_arr[gi] = bus.req_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
      assign strb_arr[gi]  = bus.req_strb[gi*STRB_WIDTH +: STRB_WIDTH];
      assign prot_arr[gi]  = bus.req_prot[gi*PROT_WIDTH +: PROT_WIDTH];
      // A requester being told "done" this cycle must not be re-granted on the same edge.
      assign eligible[gi]  = bus.req[gi] & ~done_reg[gi];
    end
  endgenerate

  assign winner      = (eligible == 2'b11) ? ~last_grant_reg : eligible[1];
  assign timeout_hit = (TIMEOUT > 0) && (wait_cnt_reg == CNT_WIDTH'(TIMEOUT - 1));

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_reg      <= IDLE;
      last_grant_reg <= 1'b1;
      grant_reg      <= 1'b0;
      wait_cnt_reg   <= '0;
      psel_reg       <= 1'b0;
      penable_reg    <= 1'b0;
      pwrite_reg     <= 1'b0;
      paddr_reg      <= '0;
      pwdata_reg     <= '0;
      pstrb_reg      <= '0;
      pprot_reg      <= '0;
      done_reg       <= '0;
      rdata_reg      <= '0;
      err_reg        <= 1'b0;
      busy_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      last_grant_reg <= last_grant_next;
      grant_reg      <= grant_next;
      wait_cnt_reg   <= wait_cnt_next;
      psel_reg       <= psel_next;
      penable_reg    <= penable_next;
      pwrite_reg     <= pwrite_next;
      paddr_reg      <= paddr_next;
      pwdata_reg     <= pwdata_next;
      pstrb_reg      <= pstrb_next;
      pprot_reg      <= pprot_next;
      done_reg       <= done_next;
      rdata_reg      <= rdata_next;
      err_reg        <= err_next;
      busy_reg       <= busy_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    last_grant_next = last_grant_reg;
    grant_next      = grant_reg;
    wait_cnt_next   = wait_cnt_reg;
    psel_next       = psel_reg;
    penable_next    = penable_reg;
    pwrite_next     = pwrite_reg;
    paddr_next      = paddr_reg;
    pwdata_next     = pwdata_reg;
    pstrb_next      = pstrb_reg;
    pprot_next      = pprot_reg;
    done_next       = '0;
    rdata_next      = '0;
    err_next        = 1'b0;

    case (state_reg)
      IDLE: begin
        if (|eligible) begin
          grant_next      = winner;
          last_grant_next = winner;
          psel_next       = 1'b1;
          penable_next    = 1'b0;
          pwrite_next     = write_arr[winner];
          paddr_next      = addr_arr[winner];
          pwdata_next     = write_arr[winner] ? wdata_arr[winner] : '0;
          pstrb_next      = write_arr[winner] ? strb_arr[winner] : '0;
          pprot_next      = prot_arr[winner];
          state_next      = SETUP;
        end
      end
      SETUP: begin
        penable_next  = 1'b1;
        wait_cnt_next = '0;
        state_next    = ACCESS;
      end
      ACCESS: begin
        if (bus.PREADY) begin
          psel_next            = 1'b0;
          penable_next         = 1'b0;
          done_next[grant_reg] = 1'b1;
          rdata_next           = pwrite_reg ? '0 : bus.PRDATA;
          err_next             = bus.PSLVERR;
          state_next           = IDLE;
        end else if (timeout_hit) begin
          psel_next            = 1'b0;
          penable_next         = 1'b0;
          done_next[grant_reg] = 1'b1;
          err_next             = 1'b1;
          state_next           = IDLE;
        end else if (wait_cnt_reg != '1) begin
          // saturate so a disabled watchdog never wraps
          wait_cnt_next = wait_cnt_reg + CNT_WIDTH'(1);
        end
      end
      default: begin
        psel_next    = 1'b0;
        penable_next = 1'b0;
        state_next   = IDLE;
      end
    endcase

    busy_next = (state_next != IDLE);
  end

  assign bus.PSEL      = psel_reg;
  assign bus.PENABLE   = penable_reg;
  assign bus.PWRITE    = pwrite_reg;
  assign bus.PADDR     = paddr_reg;
  assign bus.PWDATA    = pwdata_reg;
  assign bus.PSTRB     = pstrb_reg;
  assign bus.PPROT     = pprot_reg;
  assign bus.req_done  = done_reg;
  assign bus.req_rdata = rdata_reg;
  assign bus.req_err   = err_reg;
  assign bus.busy      = busy_reg;
endmodule

// File: tb/tb_apb_rr_master_arb.sv
// Directed bench for apb_rr_master_arb: transaction-age model checked every cycle,
// plus literal expectations on grant order, latencies, wait lengths and completion status.
module tb_apb_rr_master_arb;
  localparam int AW = 32, DW = 32, PW = 3, SW = DW / 8, TO = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  apb_rr_master_arb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PROT_WIDTH(PW)) bus();

  apb_rr_master_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PROT_WIDTH(PW), .TIMEOUT(TO)) dut (
    .PCLK(clk),
    .PRESETn(rst_n),
    .bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // model: m_age = 0 no transfer, 1 setup cycle, k>=2 the (k-1)-th access cycle
  int            m_age  = 0;
  logic          m_last = 1'b1;
  logic          m_grant = 1'b0;
  int            m_grants[$];
  logic          e_psel = 0, e_pen = 0, e_pwrite = 0, e_err = 0;
  logic [AW-1:0] e_paddr = 0;
  logic [DW-1:0] e_pwdata = 0, e_rdata = 0;
  logic [SW-1:0] e_pstrb = 0;
  logic [PW-1:0] e_pprot = 0;
  logic [1:0]    e_done = 0;

  // observations of the DUT used by the literal checks
  int            psel_rise[$], pen_rise[$], done_cyc[$], done_idx[$], acc_len[$];
  logic [DW-1:0] done_rdata[$];
  logic          done_err[$];
  logic [AW-1:0] acc_paddr[$];
  logic [SW-1:0] acc_pstrb[$];
  logic          psel_prev = 0, pen_prev = 0;
  int            cur_acc = 0;

  // APB slave behaviour
  int            slv_wait = 0;
  logic          slv_err = 0;
  logic [DW-1:0] slv_rdata = 0;
  int            resp_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_finish(input logic [DW-1:0] rd, input logic er);
    e_done  = m_grant ? 2'b10 : 2'b01;
    e_rdata = rd;
    e_err   = er;
    e_psel  = 1'b0;
    e_pen   = 1'b0;
    m_age   = 0;
  endtask

  task automatic model_step();
    logic [1:0] elig;
    logic [1:0] done_prev;
    int p;
    if (!rst_n) begin
      m_age = 0; m_last = 1'b1;
      e_psel = 0; e_pen = 0; e_pwrite = 0; e_paddr = 0; e_pwdata = 0;
      e_pstrb = 0; e_pprot = 0; e_done = 0; e_rdata = 0; e_err = 0;
      return;
    end
    done_prev = e_done;
    e_done = 0; e_rdata = 0; e_err = 0;
    if (m_age == 0) begin
      elig = bus.req & ~done_prev;
      if (elig != 2'b00) begin
        m_grant = (elig == 2'b11) ? ~m_last : elig[1];
        m_last  = m_grant;
        m_grants.push_back(int'(m_grant));
        p        = int'(m_grant);
        e_pwrite = bus.req_write[p];
        e_paddr  = bus.req_addr[p*AW +: AW];
        e_pwdata = e_pwrite ? bus.req_wdata[p*DW +: DW] : '0;
        e_pstrb  = e_pwrite ? bus.req_strb[p*SW +: SW] : '0;
        e_pprot  = bus.req_prot[p*PW +: PW];
        e_psel   = 1'b1;
        e_pen    = 1'b0;
        m_age    = 1;
      end
    end else if (m_age == 1) begin
      e_pen = 1'b1;
      m_age = 2;
    end else begin
      if (bus.PREADY)
        model_finish(e_pwrite ? '0 : bus.PRDATA, bus.PSLVERR);
      else if (TO > 0 && (m_age - 1) == TO)
        model_finish('0, 1'b1);
      else
        m_age++;
    end
  endtask

  task automatic compare();
    check("busy", bus.busy, m_age != 0);
    check("psel", bus.PSEL, e_psel);
    check("penable", bus.PENABLE, e_pen);
    check("req_done", bus.req_done, e_done);
    if (e_psel) begin
      check("pwrite", bus.PWRITE, e_pwrite);
      check("paddr", bus.PADDR, e_paddr);
      check("pwdata", bus.PWDATA, e_pwdata);
      check("pstrb", bus.PSTRB, e_pstrb);
      check("pprot", bus.PPROT, e_pprot);
    end
    if (e_done != 2'b00) begin
      check("req_rdata", bus.req_rdata, e_rdata);
      check("req_err", bus.req_err, e_err);
    end
  endtask

  task automatic observe();
    if (!rst_n) cur_acc = 0;
    if (bus.PSEL && !psel_prev) psel_rise.push_back(cyc);
    if (bus.PENABLE && !pen_prev) begin
      pen_rise.push_back(cyc);
      acc_paddr.push_back(bus.PADDR);
      acc_pstrb.push_back(bus.PSTRB);
    end
    if (bus.PSEL && bus.PENABLE) cur_acc++;
    if (bus.req_done != 2'b00) begin
      done_cyc.push_back(cyc);
      done_idx.push_back(int'(bus.req_done[1]));
      done_rdata.push_back(bus.req_rdata);
      done_err.push_back(bus.req_err);
      acc_len.push_back(cur_acc);
      $display("[TB] cyc %0d done req%0d err=%0b rdata=%08h access_cycles=%0d",
               cyc, int'(bus.req_done[1]), bus.req_err, bus.req_rdata, cur_acc);
      cur_acc = 0;
    end
    psel_prev = bus.PSEL;
    pen_prev  = bus.PENABLE;
  endtask

  // one process per negedge: step model, compare, observe, then drive the slave response
  initial begin
    bus.PREADY = 1'b0; bus.PSLVERR = 1'b0; bus.PRDATA = '0;
    forever begin
      @(negedge clk);
      cyc++;
      model_step();
      compare();
      observe();
      if (rst_n && bus.PSEL && bus.PENABLE) resp_cnt++;
      else resp_cnt = 0;
      bus.PREADY  = (resp_cnt > slv_wait);
      bus.PSLVERR = bus.PREADY & slv_err;
      bus.PRDATA  = slv_rdata;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_logs();
    psel_rise.delete(); pen_rise.delete(); done_cyc.delete(); done_idx.delete();
    acc_len.delete(); done_rdata.delete(); done_err.delete(); acc_paddr.delete();
    acc_pstrb.delete(); m_grants.delete();
  endtask

  task automatic set_req(input int i, input logic wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [SW-1:0] s, input logic [PW-1:0] p);
    bus.req_write[i]         = wr;
    bus.req_addr[i*AW +: AW] = a;
    bus.req_wdata[i*DW +: DW] = d;
    bus.req_strb[i*SW +: SW] = s;
    bus.req_prot[i*PW +: PW] = p;
  endtask

  // kind 0 = done events, 1 = PENABLE rises, 2 = PSEL rises
  task automatic wait_ev(input int kind, input int n, input int budget, input string name);
    int k = 0;
    int have;
    have = (kind == 0) ? done_cyc.size() : (kind == 1) ? pen_rise.size() : psel_rise.size();
    while (have < n && k < budget) begin
      tick();
      k++;
      have = (kind == 0) ? done_cyc.size() : (kind == 1) ? pen_rise.size() : psel_rise.size();
    end
    check(name, have >= n, 1'b1);
  endtask

  task automatic check_zero(input string pfx);
    check({pfx, "_psel"}, bus.PSEL, 0);
    check({pfx, "_penable"}, bus.PENABLE, 0);
    check({pfx, "_pwrite"}, bus.PWRITE, 0);
    check({pfx, "_paddr"}, bus.PADDR, 0);
    check({pfx, "_pwdata"}, bus.PWDATA, 0);
    check({pfx, "_pstrb"}, bus.PSTRB, 0);
    check({pfx, "_pprot"}, bus.PPROT, 0);
    check({pfx, "_done"}, bus.req_done, 0);
    check({pfx, "_rdata"}, bus.req_rdata, 0);
    check({pfx, "_err"}, bus.req_err, 0);
    check({pfx, "_busy"}, bus.busy, 0);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    int t0;
    bus.req = '0; bus.req_write = '0; bus.req_addr = '0; bus.req_wdata = '0;
    bus.req_strb = '0; bus.req_prot = '0;

    // reset state
    tick(); tick();
    check_zero("reset");
    rst_n = 1'b1;
    tick();

    // single write, zero-wait slave
    clear_logs();
    slv_wait = 0; slv_err = 0; slv_rdata = 32'h0;
    set_req(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 3'h0);
    bus.req = 2'b01; t0 = cyc;
    wait_ev(0, 1, 20, "s1_wait");
    bus.req = 2'b00;
    check("s1_psel_cyc", psel_rise[0], t0 + 1);
    check("s1_pen_cyc", pen_rise[0], t0 + 2);
    check("s1_done_cyc", done_cyc[0], t0 + 3);
    check("s1_done_idx", done_idx[0], 0);
    check("s1_err", done_err[0], 0);
    tick(); tick();

    // req withdrawn and fields changed right after grant: transfer still completes as granted
    clear_logs();
    slv_wait = 2;
    set_req(1, 1'b1, 32'h44, 32'h11223344, 4'h3, 3'h2);
    bus.req = 2'b10;
    wait_ev(2, 1, 10, "s1b_grant");
    set_req(1, 1'b0, 32'hFFFC, 32'h0, 4'hC, 3'h5);
    bus.req = 2'b00;
    wait_ev(0, 1, 20, "s1b_wait");
    check("s1b_done_idx", done_idx[0], 1);
    check("s1b_paddr", acc_paddr[0], 32'h44);
    check("s1b_acc_len", acc_len[0], 3);
    tick(); tick();

    // both requesters held from reset: strict alternation starting with requester 0
    apply_reset();
    clear_logs();
    slv_wait = 0; slv_rdata = 32'hA5A50F0F;
    set_req(0, 1'b1, 32'h100, 32'hCAFE0000, 4'hF, 3'h1);
    set_req(1, 1'b0, 32'h200, 32'hFFFFFFFF, 4'hF, 3'h0);
    bus.req = 2'b11;
    wait_ev(0, 4, 40, "s2_wait");
    bus.req = 2'b00;
    for (int j = 0; j < 4; j++) begin
      check($sformatf("s2_dut_grant%0d", j), done_idx[j], j % 2);
      check($sformatf("s2_model_grant%0d", j), m_grants[j], j % 2);
    end
    for (int j = 0; j < 3; j++)
      check($sformatf("s2_gap%0d", j), psel_rise[j+1], done_cyc[j] + 1);
    check("s2_write_rdata", done_rdata[0], 32'h0);
    check("s2_read_rdata", done_rdata[1], 32'hA5A50F0F);
    tick(); tick();

    // read by requester 1 with three wait states
    clear_logs();
    slv_wait = 3; slv_rdata = 32'h12345678;
    set_req(1, 1'b0, 32'h300, 32'hFFFFFFFF, 4'hF, 3'h0);
    bus.req = 2'b10;
    wait_ev(0, 1, 20, "s3_wait");
    bus.req = 2'b00;
    check("s3_done_idx", done_idx[0], 1);
    check("s3_acc_len", acc_len[0], 4);
    check("s3_rdata", done_rdata[0], 32'h12345678);
    check("s3_pstrb", acc_pstrb[0], 4'h0);
    check("s3_err", done_err[0], 0);
    tick(); tick();

    // slave never ready: watchdog aborts after exactly TO access cycles
    clear_logs();
    slv_wait = 1000; slv_rdata = 32'h55AA55AA;
    set_req(0, 1'b0, 32'h400, 32'h0, 4'h0, 3'h0);
    bus.req = 2'b01;
    wait_ev(0, 1, 40, "s4_wait");
    bus.req = 2'b00;
    check("s4_acc_len", acc_len[0], 16);
    check("s4_span", done_cyc[0] - pen_rise[0], 16);
    check("s4_err", done_err[0], 1);
    check("s4_rdata", done_rdata[0], 32'h0);
    tick(); tick();

    // slave error on a write
    clear_logs();
    slv_wait = 0; slv_err = 1'b1;
    set_req(0, 1'b1, 32'h500, 32'h0BADF00D, 4'h5, 3'h4);
    bus.req = 2'b01;
    wait_ev(0, 1, 20, "s5_wait");
    bus.req = 2'b00;
    slv_err = 1'b0;
    check("s5_err", done_err[0], 1);
    check("s5_done_idx", done_idx[0], 0);
    tick(); tick();

    // reset in the middle of ACCESS abandons the transfer; held request is served afterwards
    clear_logs();
    slv_wait = 1000;
    set_req(0, 1'b0, 32'h600, 32'h0, 4'h0, 3'h3);
    bus.req = 2'b01;
    wait_ev(1, 1, 10, "s6_access");
    tick(); tick();
    rst_n = 1'b0;
    #1;
    check_zero("s6_async");
    tick(); tick();
    check("s6_no_done", done_cyc.size(), 0);
    clear_logs();
    slv_wait = 0;
    rst_n = 1'b1; t0 = cyc;
    wait_ev(0, 1, 20, "s6_wait");
    bus.req = 2'b00;
    check("s6_psel_cyc", psel_rise[0], t0 + 1);
    check("s6_done_idx", done_idx[0], 0);
    check("s6_acc_len", acc_len[0], 1);
    tick(); tick(); tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
